// File: rtl/cpu_arbiter.sv
// cpu_arbiter: round-robin merge of CPU_NB cpu streams into one output slot.
// Optional grant_count statistics when CPU_ARBITER_STATS_EN is defined.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cpu_data_vld[CPU_NB]   per-cpu valid
//   cpu_data[CPU_NB*64]    per-cpu data, cpu i at [i*64 +: 64]
//   cpu_data_rdy[CPU_NB]   per-cpu grant, one-hot or zero
//   cpu_transactions_done  per-cpu sticky done flags
//   out_vld/out_data/out_index/out_rdy  merged output stream
//   all_done               sticky: all cpus done, slot empty, no requests
//   grant_count[CPU_NB*32] per-cpu transfer counters (stats build only)

module cpu_arbiter #(
  parameter int CPU_NB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_NB-1:0]    cpu_data_vld,
  input  logic [CPU_NB*64-1:0] cpu_data,
  output logic [CPU_NB-1:0]    cpu_data_rdy,
  input  logic [CPU_NB-1:0]    cpu_transactions_done,
  output logic                 out_vld,
  output logic [63:0]          out_data,
  output logic [31:0]          out_index,
  input  logic                 out_rdy,
  output logic                 all_done
`ifdef CPU_ARBITER_STATS_EN
  ,
  output logic [CPU_NB*32-1:0] grant_count
`endif
);

  localparam int PW = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] idx_q;
  logic [63:0]   data_q;

  logic          hit_hi;
  logic          hit_lo;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] rr_nxt;
  logic [63:0]   gnt_data;
  logic          slot_free;
  logic          xfer;

  // Two-pass scan: first requester at or above rr_ptr,
  // otherwise the lowest requester (the wrapped part).
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      if (!hit_hi && cpu_data_vld[i]
          && i >= int'(rr_ptr)) begin
        hit_hi = 1'b1;
        hi_idx = PW'(i);
      end
      if (!hit_lo && cpu_data_vld[i]) begin
        hit_lo = 1'b1;
        lo_idx = PW'(i);
      end
    end
  end

  assign gnt_any = hit_hi | hit_lo;
  assign gnt_idx = hit_hi ? hi_idx : lo_idx;

  always_comb begin
    if (int'(gnt_idx) == CPU_NB - 1)
      rr_nxt = '0;
    else
      rr_nxt = gnt_idx + PW'(1);
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      if (gnt_idx == PW'(i))
        gnt_data = cpu_data[i*64 +: 64];
    end
  end

  // Free slot: empty, or full and draining this cycle.
  assign slot_free = (state_q == EMPTY) || out_rdy;
  assign xfer      = !rst && slot_free && gnt_any;

  always_comb begin
    cpu_data_rdy = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      cpu_data_rdy[i] = xfer && (gnt_idx == PW'(i));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (xfer)
          state_d = FULL;
      end
      FULL: begin
        if (xfer)
          state_d = FULL;
        else if (out_rdy)
          state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    out_vld   = (state_q == FULL);
    out_data  = data_q;
    out_index = 32'(idx_q);
  end

  // Slot payload and round-robin pointer move only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      data_q <= gnt_data;
      idx_q  <= gnt_idx;
      rr_ptr <= rr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      all_done <= 1'b0;
    else if (!all_done)
      all_done <= (&cpu_transactions_done)
                  && (state_q == EMPTY)
                  && !(|cpu_data_vld);
  end

`ifdef CPU_ARBITER_STATS_EN
  for (genvar g = 0; g < CPU_NB; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)
        grant_count[g*32 +: 32] <= '0;
      else if (cpu_data_rdy[g])
        grant_count[g*32 +: 32] <=
          grant_count[g*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule
